// File: rtl/rect_fill_writer_pkg.sv
// Shared constants and FSM encoding for the rectangle fill writer and the video timing logic.
package rect_fill_writer_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ADDR_W       = 19;
  localparam int PIX_W        = 24;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int END_W        = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Constant multiply unrolled into shifted adds (640 -> y<<9 + y<<7).
  function automatic logic [ADDR_W-1:0] mul_by_const(input logic [Y_W-1:0] y, input int k);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (k[i]) begin
        acc = acc + (ADDR_W'(y) << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction
endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle against the visible area, plus the empty-rectangle flag.
module rect_clip
  import rect_fill_writer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic [X_W-1:0]   x_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic [X_W-1:0]   w_i,
  input  logic [Y_W-1:0]   h_i,
  output logic [END_W-1:0] x_end_o,
  output logic [END_W-1:0] y_end_o,
  output logic             empty_o
);
  localparam logic [END_W-1:0] H_LIM = END_W'(H_ACTIVE);
  localparam logic [END_W-1:0] V_LIM = END_W'(V_ACTIVE);

  logic [END_W-1:0] x_sum;
  logic [END_W-1:0] y_sum;

  // Sums fit in 11 bits (max 1023+1023), so no overflow before clamping.
  always_comb begin
    x_sum   = END_W'(x_i) + END_W'(w_i);
    y_sum   = END_W'(y_i) + END_W'(h_i);
    x_end_o = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end_o = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty_o = (w_i == 10'd0) || (h_i == 9'd0) ||
              (END_W'(x_i) >= H_LIM) || (END_W'(y_i) >= V_LIM);
  end
endmodule

// File: rtl/rect_fill_writer.sv
// Fills a clipped rectangle of the framebuffer with one colour, one pixel per clock, row-major.
module rect_fill_writer
  import rect_fill_writer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_x,
  input  logic [Y_W-1:0]    cmd_y,
  input  logic [X_W-1:0]    cmd_w,
  input  logic [Y_W-1:0]    cmd_h,
  input  logic [PIX_W-1:0]  cmd_color,
  input  logic              abort,
  output logic [ADDR_W-1:0] write_addr,
  output logic [PIX_W-1:0]  write_data,
  output logic              wren_signal,
  output logic              busy,
  output logic              done
);
  state_e             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d, w_q, w_d;
  logic [Y_W-1:0]     y_q, y_d, h_q, h_d;
  logic [PIX_W-1:0]   color_q, color_d;
  logic [END_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [ADDR_W-1:0]  row_q, row_d, addr_q, addr_d;
  logic [PIX_W-1:0]   data_q, data_d;
  logic               wren_q, wren_d, done_q, done_d;

  logic [END_W-1:0]   x_end, y_end;
  logic               empty;
  logic [ADDR_W-1:0]  row_base;
  logic               last_col, last_row;

  rect_clip #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_clip (
    .x_i(x_q), .y_i(y_q), .w_i(w_q), .h_i(h_q),
    .x_end_o(x_end), .y_end_o(y_end), .empty_o(empty)
  );

  assign row_base = mul_by_const(y_q, H_ACTIVE) + ADDR_W'(x_q);
  assign last_col = (cur_x_q + END_W'(1)) == x_end;
  assign last_row = (cur_y_q + END_W'(1)) == y_end;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    x_d = x_q;  y_d = y_q;  w_d = w_q;  h_d = h_q;
    color_d = color_q;
    cur_x_d = cur_x_q;  cur_y_d = cur_y_q;
    row_d   = row_q;    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          x_d = cmd_x;  y_d = cmd_y;  w_d = cmd_w;  h_d = cmd_h;
          color_d = cmd_color;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        data_d = color_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FILL;
          wren_d  = 1'b1;
          addr_d  = row_base;
          row_d   = row_base;
          cur_x_d = END_W'(x_q);
          cur_y_d = END_W'(y_q);
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_col && last_row) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (last_col) begin
          wren_d  = 1'b1;
          cur_x_d = END_W'(x_q);
          cur_y_d = cur_y_q + END_W'(1);
          row_d   = row_q + ADDR_W'(H_ACTIVE);
          addr_d  = row_q + ADDR_W'(H_ACTIVE);
        end else begin
          wren_d  = 1'b1;
          cur_x_d = cur_x_q + END_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the write strobe asynchronously.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q <= '0;  y_q <= '0;  w_q <= '0;  h_q <= '0;
      color_q <= '0;
      cur_x_q <= '0;  cur_y_q <= '0;
      row_q   <= '0;  addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;  y_q <= y_d;  w_q <= w_d;  h_q <= h_d;
      color_q <= color_d;
      cur_x_q <= cur_x_d;  cur_y_q <= cur_y_d;
      row_q   <= row_d;    addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign write_addr  = addr_q;
  assign write_data  = data_q;
  assign wren_signal = wren_q;
  assign done        = done_q;
endmodule

// File: tb/tb_rect_fill_writer.sv
// Scoreboard bench for rect_fill_writer: directed commands push expected writes, a monitor checks them.
module tb_rect_fill_writer;
  logic        vga_clk, reset, cmd_valid, cmd_ready, abort;
  logic [9:0]  cmd_x, cmd_w;
  logic [8:0]  cmd_y, cmd_h;
  logic [23:0] cmd_color, write_data;
  logic [18:0] write_addr;
  logic        wren_signal, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = -1;
  logic [42:0] exp_q[$];
  logic [42:0] exp_e;

  rect_fill_writer dut (
    .vga_clk(vga_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .abort(abort), .write_addr(write_addr), .write_data(write_data),
    .wren_signal(wren_signal), .busy(busy), .done(done)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [18:0] a, input logic [23:0] c);
    exp_q.push_back({a, c});
  endtask

  // Monitor: every strobed write must match the head of the scoreboard.
  always @(negedge vga_clk) begin
    if (wren_signal === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d expected no write", write_addr);
      end else begin
        exp_e = exp_q.pop_front();
        chk("write_addr", 32'(write_addr), 32'(exp_e[42:24]));
        chk("write_data", 32'(write_data), 32'(exp_e[23:0]));
      end
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic issue(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                       input logic [8:0] h, input logic [23:0] c, output int hs);
    @(negedge vga_clk);
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    @(posedge vga_clk); #1;
    hs = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge vga_clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done pulse expected one within 200 cycles");
    end else begin
      @(negedge vga_clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("ready_after_done", 32'(cmd_ready), 32'd1);
    end
  endtask

  int hs, hs2, dc, dc2, w0, d0;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(negedge vga_clk);
    chk("rst_wren", 32'(wren_signal), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    chk("rst_data", 32'(write_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge vga_clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Nominal 3x2 fill
    w0 = wr_cnt;
    push(19'd1290, 24'h00FF00); push(19'd1291, 24'h00FF00); push(19'd1292, 24'h00FF00);
    push(19'd1930, 24'h00FF00); push(19'd1931, 24'h00FF00); push(19'd1932, 24'h00FF00);
    issue(10'd10, 9'd2, 10'd3, 9'd2, 24'h00FF00, hs);
    @(negedge vga_clk);
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_no_write", 32'(wren_signal), 32'd0);
    @(negedge vga_clk);
    chk("first_write_latency", 32'(wren_signal), 32'd1);
    wait_done(dc);
    chk("nominal_count", 32'(wr_cnt - w0), 32'd6);
    chk("nominal_done_time", 32'(dc), 32'(last_wr_cyc + 1));

    // Right/bottom clip
    w0 = wr_cnt;
    push(19'd307198, 24'h123456); push(19'd307199, 24'h123456);
    issue(10'd638, 9'd479, 10'd5, 9'd4, 24'h123456, hs);
    wait_done(dc);
    chk("clip_count", 32'(wr_cnt - w0), 32'd2);
    chk("clip_done_time", 32'(dc), 32'(last_wr_cyc + 1));

    // Empty: zero width, then x off-screen
    w0 = wr_cnt;
    issue(10'd5, 9'd5, 10'd0, 9'd3, 24'h777777, hs);
    wait_done(dc);
    chk("empty_w_count", 32'(wr_cnt - w0), 32'd0);
    chk("empty_w_done_time", 32'(dc), 32'(hs + 1));
    issue(10'd640, 9'd0, 10'd4, 9'd4, 24'h777777, hs);
    wait_done(dc);
    chk("empty_x_count", 32'(wr_cnt - w0), 32'd0);
    chk("empty_x_done_time", 32'(dc), 32'(hs + 1));

    // Abort on the 3rd FILL cycle of a 4x4 fill
    w0 = wr_cnt; d0 = done_cnt;
    push(19'd0, 24'hAABBCC); push(19'd1, 24'hAABBCC); push(19'd2, 24'hAABBCC);
    issue(10'd0, 9'd0, 10'd4, 9'd4, 24'hAABBCC, hs);
    repeat (4) @(negedge vga_clk);
    abort = 1'b1;
    @(negedge vga_clk);
    abort = 1'b0;
    chk("abort_wren", 32'(wren_signal), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (5) @(negedge vga_clk);
    chk("abort_count", 32'(wr_cnt - w0), 32'd3);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));

    // abort together with cmd_valid in IDLE: command still accepted
    w0 = wr_cnt;
    push(19'd5, 24'h000001);
    @(negedge vga_clk);
    abort = 1'b1; cmd_valid = 1'b1;
    cmd_x = 10'd5; cmd_y = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 24'h000001;
    @(posedge vga_clk); #1;
    abort = 1'b0; cmd_valid = 1'b0;
    chk("abort_idle_accept", 32'(busy), 32'd1);
    wait_done(dc);
    chk("abort_idle_count", 32'(wr_cnt - w0), 32'd1);

    // Back-to-back, with fields changed while busy
    w0 = wr_cnt;
    push(19'd640, 24'h0000FF); push(19'd641, 24'h0000FF); push(19'd1923, 24'hFF0000);
    @(negedge vga_clk);
    cmd_valid = 1'b1; cmd_x = 10'd0; cmd_y = 9'd1; cmd_w = 10'd2; cmd_h = 9'd1; cmd_color = 24'h0000FF;
    @(posedge vga_clk); #1;
    hs = cyc;
    cmd_x = 10'd3; cmd_y = 9'd3; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 24'hFF0000;
    wait_done(dc);
    @(posedge vga_clk); #1;
    hs2 = cyc;
    cmd_valid = 1'b0;
    chk("b2b_handshake_time", 32'(hs2), 32'(dc + 2));
    wait_done(dc2);
    chk("b2b_count", 32'(wr_cnt - w0), 32'd3);
    chk("b2b_done_time", 32'(dc2), 32'(last_wr_cyc + 1));

    // Reset mid-FILL
    w0 = wr_cnt; d0 = done_cnt;
    push(19'd6400, 24'h0F0F0F);
    issue(10'd0, 9'd10, 10'd4, 9'd4, 24'h0F0F0F, hs);
    repeat (2) @(negedge vga_clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_wren", 32'(wren_signal), 32'd0);
    chk("midrst_addr", 32'(write_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge vga_clk);
    reset = 1'b0;
    @(negedge vga_clk);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_count", 32'(wr_cnt - w0), 32'd1);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    w0 = wr_cnt;
    push(19'd0, 24'h0A0B0C);
    issue(10'd0, 9'd0, 10'd1, 9'd1, 24'h0A0B0C, hs);
    wait_done(dc);
    chk("post_rst_count", 32'(wr_cnt - w0), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
